// File: rtl/fir_stream_feeder_pkg.sv
// fir_stream_feeder_pkg: shared types, default sizing and width helper for the FIR stream feeder
package fir_stream_feeder_pkg;
    typedef logic [31:0] fp_32_t;
    typedef enum logic [2:0] {IDLE, FIR_RST, LOAD_COEF, EMIT_COEF, STREAM, DRAIN} feeder_state_t;
    localparam int DEF_NUM_TAPS = 4;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_SAMPLE_INTERVAL = 2;
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: single-clock FIFO; pointers carry one extra wrap bit to tell full from empty
module fir_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clock) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/fir_stream_feeder.sv
// fir_stream_feeder: loads FIR coefficients, replays them back-to-back, then paces buffered samples onto fir_x
module fir_stream_feeder
    import fir_stream_feeder_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        start,
    input  logic        stop,
    input  logic        coef_valid,
    input  logic [31:0] coef_data,
    output logic        coef_ready,
    input  logic        sample_valid,
    input  logic [31:0] sample_data,
    output logic        sample_ready,
    output logic        fir_resetN,
    output logic [31:0] fir_x,
    output logic        busy,
    output logic [15:0] underrun_cnt
);
    localparam int ZERO_CYCLES = NUM_TAPS * SAMPLE_INTERVAL;
    localparam int CW = cnt_width(ZERO_CYCLES);
    localparam int SW = cnt_width(SAMPLE_INTERVAL);
    localparam int IW = $clog2(NUM_TAPS);
    feeder_state_t state, state_d;
    fp_32_t coef_buf [NUM_TAPS];
    fp_32_t fir_x_d;
    fp_32_t head;
    logic [IW-1:0] idx, idx_d, emit_idx;
    logic [CW-1:0] cnt, cnt_d;
    logic [SW-1:0] slot, slot_d;
    logic stop_q, stop_d, zero_q, zero_d;
    logic pop, push, full, empty, coef_we, underrun_inc, slot_last;
    assign sample_ready = !full && (state inside {LOAD_COEF, EMIT_COEF, STREAM});
    assign push = sample_valid && sample_ready;
    assign slot_last = slot == SW'(SAMPLE_INTERVAL - 1);
    assign emit_idx = IW'(NUM_TAPS - 1 - int'(cnt));
    fir_sample_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .resetN    (resetN),
        .push      (push),
        .push_data (sample_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );
    // fir_x_d is the value fir_x will hold in the cycle after this one
    always_comb begin
        state_d = state;
        idx_d = idx;
        cnt_d = cnt;
        slot_d = slot;
        stop_d = stop_q;
        zero_d = zero_q;
        fir_x_d = '0;
        pop = 1'b0;
        coef_we = 1'b0;
        underrun_inc = 1'b0;
        case (state)
            IDLE: state_d = start ? FIR_RST : IDLE;
            FIR_RST: begin
                state_d = LOAD_COEF;
                idx_d = '0;
            end
            LOAD_COEF: if (coef_valid) begin
                coef_we = 1'b1;
                idx_d = idx + 1'b1;
                if (idx == IW'(NUM_TAPS - 1)) begin
                    state_d = EMIT_COEF;
                    cnt_d = '0;
                end
            end
            EMIT_COEF: if (cnt == CW'(NUM_TAPS)) begin
                state_d = STREAM;
                slot_d = '0;
                stop_d = 1'b0;
                pop = !empty;
                fir_x_d = empty ? '0 : head;
                underrun_inc = empty;
            end else begin
                cnt_d = cnt + 1'b1;
                fir_x_d = coef_buf[emit_idx];
            end
            STREAM: begin
                stop_d = stop_q || stop;
                if (slot_last) begin
                    slot_d = '0;
                    pop = !empty;
                    fir_x_d = empty ? '0 : head;
                    if (stop_q || stop) begin
                        state_d = DRAIN;
                        zero_d = empty;
                        cnt_d = '0;
                    end else begin
                        underrun_inc = empty;
                    end
                end else begin
                    slot_d = slot + 1'b1;
                    fir_x_d = fir_x;
                end
            end
            DRAIN: if (zero_q) begin
                if (cnt == CW'(ZERO_CYCLES - 1)) begin
                    state_d = IDLE;
                    zero_d = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end else if (slot_last) begin
                slot_d = '0;
                pop = !empty;
                fir_x_d = empty ? '0 : head;
                zero_d = empty;
                cnt_d = '0;
            end else begin
                slot_d = slot + 1'b1;
                fir_x_d = fir_x;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            slot <= '0;
            stop_q <= 1'b0;
            zero_q <= 1'b0;
            fir_x <= '0;
            fir_resetN <= 1'b0;
            busy <= 1'b0;
            coef_ready <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state <= state_d;
            idx <= idx_d;
            cnt <= cnt_d;
            slot <= slot_d;
            stop_q <= stop_d;
            zero_q <= zero_d;
            fir_x <= fir_x_d;
            fir_resetN <= !(state_d inside {IDLE, FIR_RST});
            busy <= state_d != IDLE;
            coef_ready <= state_d == LOAD_COEF;
            if (underrun_inc && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
    always_ff @(posedge clock) begin
        if (coef_we) coef_buf[idx] <= coef_data;
    end
endmodule
